ll_rx_marker_align_mon: RTL and testbench
=========================================

// Module: ll_rx_marker_align_mon
// PURPOSE
// - RX-side word-alignment monitor for a 4-channel Tier2 link. Watches persistent marker bits in the raw PHY receive
//   word and declares alignment after consecutive correct markers. Its alignment output drives the rx_online input
//   of the slave top; it sits between the AIB PHY receive path and the auto-sync block.
// - Drops alignment after a run of consecutive bad markers and latches a sticky loss flag.
// PARAMETERS
// - PHY_WIDTH     320      raw PHY receive word width; must be 320.
// - MARKER_WIDTH  4        marker bits checked per PHY word.
// - EXP_MRK       4'b1000  expected marker pattern, bit i = marker of 80-bit word i.
// PORTS
// - clk_wr                 in   1    logic-link clock; sole clock.
// - rst_wr_n               in   1    asynchronous active-low reset.
// - align_enable           in   1    1 = monitoring; 0 = return to IDLE and clear counters and sticky flag.
// - m_gen2_mode            in   1    1: marker i at rx_phy0[80*i+79]; 0: marker i at rx_phy0[40*i+39].
// - rx_phy0                in   320  raw PHY receive word, one new word every clk_wr.
// - lock_count_value       in   8    consecutive matches needed to lock; 0 is treated as 1.
// - loss_count_value       in   8    consecutive mismatches needed to lose lock; 0 is treated as 1.
// - rx_align_done          out  1    registered; high while in LOCKED.
// - rx_align_lost          out  1    sticky; set on LOCKED->SEARCH, cleared only when align_enable=0.
// - rx_align_debug_status  out  32   see BEHAVIOUR.
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, all counters 0.
// - Stage 1: the MARKER_WIDTH marker bits selected by m_gen2_mode are registered into mrk_q, with valid_q=align_enable.
// - Stage 2: match = (mrk_q == EXP_MRK) && valid_q, evaluated combinationally from stage-1 registers.
// - match_cnt: 8-bit; increments on match, cleared on mismatch. Saturates at 255.
// - miss_cnt: 8-bit; increments on mismatch while LOCKED, cleared on match. Saturates at 255.
// - Effective thresholds: L = max(lock_count_value,1), M = max(loss_count_value,1). Both are sampled live.
// - FSM states (2 bits):
//   - IDLE=0: go to SEARCH when align_enable=1.
//   - SEARCH=1: go to LOCKED when match && match_cnt+1 >= L.
//   - LOCKED=2: go to SEARCH when !match && miss_cnt+1 >= M.
//   - State 3 is unreachable; decode it as IDLE.
// - align_enable=0 in any state forces IDLE on the next edge and clears match_cnt, miss_cnt and rx_align_lost.
//   Enable has priority over all other transitions.
// - Latency: if the N-th consecutive matching word is presented at edge k (N=L), rx_align_done=1 after edge k+2.
//   Loss is symmetric: rx_align_done=0 after edge k+2 of the M-th consecutive miss.
// - Entering SEARCH from LOCKED clears match_cnt. The mismatching word that caused the loss does not count as a
//   match, so relock needs L fresh matches.
// - A single mismatch in SEARCH restarts the match count at 0. A single match in LOCKED clears miss_cnt.
// - m_gen2_mode change mid-run: no special handling. Markers then mismatch and the normal loss rules apply.
// - lock_loss_cnt: 8-bit, +1 per LOCKED->SEARCH transition, saturates at 255, cleared in IDLE.
// - rx_align_debug_status fields:
//   - [31:30] state; [29] rx_align_lost; [28] rx_align_done; [27:24] mrk_q.
//   - [23:16] match_cnt; [15:8] miss_cnt; [7:0] lock_loss_cnt.
// - All outputs come straight from flops. No combinational path from inputs to outputs.
// TESTING
// - Reset release with align_enable=0 and random rx_phy0 -> all outputs 0 and debug status 32'h0 indefinitely.
// - Gen2, L=8: 8 words with bits 319=1 and 79/159/239=0 -> rx_align_done rises exactly 2 edges after the 8th word.
//   With only 7 such words followed by 1 bad word, rx_align_done stays 0 and match_cnt returns to 0.
// - Locked, M=3: 2 bad words, 1 good, 2 bad -> stays locked. A 3rd consecutive bad word -> done falls,
//   lost=1, lock_loss_cnt=1. Then 8 good words -> relocks with lost still 1.
// - Gen1 (m_gen2_mode=0), L=0: one word with bit 159=1 and bits 39/79/119=0 -> locks after 2 edges (0 treated as 1).
// - Locked, then align_enable=0 for 1 cycle -> next edge state IDLE, done=0, lost=0, all counters 0.
//   Async reset mid-SEARCH -> all outputs 0 immediately.
// - 300 cycles of bad markers while locked with M=255 -> miss_cnt saturates at 255 and lock is lost at the 255th miss.
//   Repeating 300 lock/loss cycles -> lock_loss_cnt holds at 255.

Source files
------------

// File: rtl/ll_rx_marker_align_mon.sv
// RX word-alignment monitor: samples the persistent marker bits of each raw PHY word,
// declares alignment after a run of good markers and drops it after a run of bad ones.
module ll_rx_marker_align_mon #(
    parameter int                      PHY_WIDTH    = 320,
    parameter int                      MARKER_WIDTH = 4,
    parameter logic [MARKER_WIDTH-1:0] EXP_MRK      = 4'b1000
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic                 align_enable,
    input  logic                 m_gen2_mode,
    input  logic [PHY_WIDTH-1:0] rx_phy0,
    input  logic [7:0]           lock_count_value,
    input  logic [7:0]           loss_count_value,
    output logic                 rx_align_done,
    output logic                 rx_align_lost,
    output logic [31:0]          rx_align_debug_status
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]              state, nxt_state;
    logic [MARKER_WIDTH-1:0] mrk_sel, mrk_q;
    logic                    valid_q;
    logic [7:0]              match_cnt, miss_cnt, lock_loss_cnt;
    logic [7:0]              lock_thr, loss_thr;
    logic                    match, lock_hit, loss_hit, lose;

    // Gen2 carries one marker per 80-bit word, Gen1 one per 40-bit half word.
    for (genvar i = 0; i < MARKER_WIDTH; i++) begin : g_mrk
        assign mrk_sel[i] = m_gen2_mode ? rx_phy0[80*i+79] : rx_phy0[40*i+39];
    end

    // Only the marker bits are consumed; the payload is deliberately ignored.
    logic unused_payload;
    assign unused_payload = ^rx_phy0;

    always_comb begin
        lock_thr  = (lock_count_value == 8'd0) ? 8'd1 : lock_count_value;
        loss_thr  = (loss_count_value == 8'd0) ? 8'd1 : loss_count_value;
        match     = valid_q && (mrk_q == EXP_MRK);
        lock_hit  = ({1'b0, match_cnt} + 9'd1) >= {1'b0, lock_thr};
        loss_hit  = ({1'b0, miss_cnt} + 9'd1) >= {1'b0, loss_thr};
        lose      = (state == LOCKED) && !match && loss_hit;
        nxt_state = state;
        case (state)
            SEARCH:  if (match && lock_hit) nxt_state = LOCKED;
            LOCKED:  if (lose) nxt_state = SEARCH;
            default: nxt_state = SEARCH;
        endcase
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state         <= IDLE;
            mrk_q         <= '0;
            valid_q       <= 1'b0;
            match_cnt     <= 8'd0;
            miss_cnt      <= 8'd0;
            lock_loss_cnt <= 8'd0;
            rx_align_done <= 1'b0;
            rx_align_lost <= 1'b0;
        end else if (!align_enable) begin
            // Disable dominates everything and keeps the debug word at zero.
            state         <= IDLE;
            mrk_q         <= '0;
            valid_q       <= 1'b0;
            match_cnt     <= 8'd0;
            miss_cnt      <= 8'd0;
            lock_loss_cnt <= 8'd0;
            rx_align_done <= 1'b0;
            rx_align_lost <= 1'b0;
        end else begin
            state         <= nxt_state;
            mrk_q         <= mrk_sel;
            valid_q       <= 1'b1;
            rx_align_done <= (state == LOCKED);
            if (lose) rx_align_lost <= 1'b1;

            if (!match)                   match_cnt <= 8'd0;
            else if (match_cnt != 8'hff)  match_cnt <= match_cnt + 8'd1;

            if (match)                                          miss_cnt <= 8'd0;
            else if ((state == LOCKED) && (miss_cnt != 8'hff))  miss_cnt <= miss_cnt + 8'd1;

            if ((state != SEARCH) && (state != LOCKED))   lock_loss_cnt <= 8'd0;
            else if (lose && (lock_loss_cnt != 8'hff))    lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end

    assign rx_align_debug_status = {state, rx_align_lost, rx_align_done, mrk_q,
                                    match_cnt, miss_cnt, lock_loss_cnt};

endmodule

// File: tb/tb_ll_rx_marker_align_mon.sv
// Bench for ll_rx_marker_align_mon: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the alignment rules.
module tb_ll_rx_marker_align_mon;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         gen2 = 1'b1;
    logic [319:0] rx = '0;
    logic [7:0]   lock_v = 8'd8;
    logic [7:0]   loss_v = 8'd3;
    logic         done, lost;
    logic [31:0]  dbg;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ll_rx_marker_align_mon dut (
        .clk_wr(clk), .rst_wr_n(rst_n), .align_enable(en), .m_gen2_mode(gen2),
        .rx_phy0(rx), .lock_count_value(lock_v), .loss_count_value(loss_v),
        .rx_align_done(done), .rx_align_lost(lost), .rx_align_debug_status(dbg)
    );

    // Reference model: phase 0=idle 1=search 2=locked; counts kept as plain ints.
    int          m_phase, m_mc, m_ms, m_llc;
    logic [3:0]  m_mrk;
    logic        m_vld, m_done, m_lost;
    int          n_phase, n_mc, n_ms, n_llc, thr_l, thr_m;
    logic [3:0]  n_mrk;
    logic        n_vld, n_done, n_lost, good_now, drop;

    always_comb begin
        thr_l    = (lock_v == 0) ? 1 : int'(lock_v);
        thr_m    = (loss_v == 0) ? 1 : int'(loss_v);
        good_now = m_vld && (m_mrk == 4'b1000);
        drop     = (m_phase == 2) && !good_now && (m_ms + 1 >= thr_m);
        n_phase = 0; n_mc = 0; n_ms = 0; n_llc = 0;
        n_mrk = 4'h0; n_vld = 1'b0; n_done = 1'b0; n_lost = 1'b0;
        if (en) begin
            n_mrk  = gen2 ? {rx[319], rx[239], rx[159], rx[79]} : {rx[159], rx[119], rx[79], rx[39]};
            n_vld  = 1'b1;
            n_done = (m_phase == 2);
            n_mc   = good_now ? ((m_mc >= 255) ? 255 : m_mc + 1) : 0;
            n_ms   = good_now ? 0 : (m_phase == 2) ? ((m_ms >= 255) ? 255 : m_ms + 1) : m_ms;
            n_lost = m_lost || drop;
            if (m_phase == 1)      n_phase = (good_now && m_mc + 1 >= thr_l) ? 2 : 1;
            else if (m_phase == 2) n_phase = drop ? 1 : 2;
            else                   n_phase = 1;
            if (m_phase == 1 || m_phase == 2) n_llc = drop ? ((m_llc >= 255) ? 255 : m_llc + 1) : m_llc;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_mc <= 0; m_ms <= 0; m_llc <= 0;
            m_mrk <= 4'h0; m_vld <= 1'b0; m_done <= 1'b0; m_lost <= 1'b0;
        end else begin
            m_phase <= n_phase; m_mc <= n_mc; m_ms <= n_ms; m_llc <= n_llc;
            m_mrk <= n_mrk; m_vld <= n_vld; m_done <= n_done; m_lost <= n_lost;
        end
    end

    function automatic logic [31:0] model_dbg();
        logic [1:0] ph;
        logic [7:0] a, b, c;
        ph = 2'(m_phase); a = 8'(m_mc); b = 8'(m_ms); c = 8'(m_llc);
        return {ph, m_lost, m_done, m_mrk, a, b, c};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every wait goes through here so the model comparison runs on each cycle.
    task automatic cyc();
        @(negedge clk);
        if (rst_n) begin
            chk("model_done", {31'd0, done}, {31'd0, m_done});
            chk("model_lost", {31'd0, lost}, {31'd0, m_lost});
            chk("model_dbg", dbg, model_dbg());
        end
    endtask

    function automatic logic [319:0] mk(input bit good, input logic g2);
        logic [319:0] w;
        logic [3:0]   m;
        for (int j = 0; j < 10; j++) w[32*j +: 32] = $urandom;
        m = 4'b1000;
        if (!good) begin
            m = 4'($urandom_range(0, 15));
            if (m == 4'b1000) m = 4'b0000;
        end
        for (int i = 0; i < 4; i++) begin
            if (g2) w[80*i+79] = m[i];
            else    w[40*i+39] = m[i];
        end
        return w;
    endfunction

    task automatic put(input bit good);
        cyc();
        rx = mk(good, gen2);
    endtask

    initial begin
        int first;
        rx = mk(1'b0, 1'b1);
        #23 rst_n = 1'b1;

        // Disabled: everything stays zero regardless of the receive data.
        repeat (20) put(bit'($urandom_range(0, 1)));
        cyc();
        chk("idle_dbg", dbg, 32'h0);
        chk("idle_done", {31'd0, done}, 32'd0);

        // Gen2, L=8: seven good words then a bad one must not lock.
        en = 1'b1;
        repeat (3) put(1'b0);
        repeat (7) put(1'b1);
        put(1'b0);
        cyc(); cyc();
        chk("seven_mc", {24'd0, dbg[23:16]}, 32'd0);
        chk("seven_done", {31'd0, done}, 32'd0);

        // Eight good words: done rises two edges after the eighth is sampled.
        repeat (8) put(1'b1);
        cyc(); chk("lock_k0", {31'd0, done}, 32'd0);
        cyc(); chk("lock_k1", {31'd0, done}, 32'd0);
               chk("lock_state", {30'd0, dbg[31:30]}, 32'd2);
        cyc(); chk("lock_k2", {31'd0, done}, 32'd1);

        // M=3: broken runs of misses keep the lock.
        put(1'b0); put(1'b0); put(1'b1); put(1'b0); put(1'b0); put(1'b1);
        repeat (3) cyc();
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_lost", {31'd0, lost}, 32'd0);
        repeat (3) put(1'b0);
        cyc(); cyc();
        chk("loss_state", {30'd0, dbg[31:30]}, 32'd1);
        chk("loss_lost", {31'd0, lost}, 32'd1);
        chk("loss_llc", {24'd0, dbg[7:0]}, 32'd1);
        chk("loss_done_lag", {31'd0, done}, 32'd1);
        cyc();
        chk("loss_done", {31'd0, done}, 32'd0);
        repeat (8) put(1'b1);
        repeat (3) cyc();
        chk("relock_done", {31'd0, done}, 32'd1);
        chk("relock_lost", {31'd0, lost}, 32'd1);

        // One disabled cycle wipes state, counters and the sticky flag.
        cyc(); en = 1'b0;
        cyc(); en = 1'b1;
        chk("dis_dbg", dbg, 32'h0);
        chk("dis_lost", {31'd0, lost}, 32'd0);

        // Gen1 with L=0 locks on a single good word.
        gen2 = 1'b0; lock_v = 8'd0;
        put(1'b0); put(1'b0); put(1'b1);
        cyc(); chk("g1_k0", {31'd0, done}, 32'd0);
        cyc(); chk("g1_state", {30'd0, dbg[31:30]}, 32'd2);
        cyc(); chk("g1_done", {31'd0, done}, 32'd1);

        // Asynchronous reset while searching.
        loss_v = 8'd1;
        put(1'b0); cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dbg", dbg, 32'h0);
        chk("arst_flags", {30'd0, lost, done}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;

        // M=255: miss counter saturates, lock drops exactly at the 255th miss.
        gen2 = 1'b1; lock_v = 8'd1; loss_v = 8'd255;
        put(1'b1);
        repeat (3) cyc();
        chk("sat_locked", {31'd0, done}, 32'd1);
        put(1'b0);
        first = -1;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (dbg[31:30] != 2'd2 && first < 0) first = i;
        end
        chk("sat_loss_at", 32'(first), 32'd255);
        chk("sat_miss", {24'd0, dbg[15:8]}, 32'd255);

        // 300 lock/loss cycles: loss counter holds at 255.
        loss_v = 8'd1;
        repeat (300) begin put(1'b1); put(1'b0); end
        repeat (3) cyc();
        chk("llc_sat", {24'd0, dbg[7:0]}, 32'd255);

        // Randomized traffic against the model.
        for (int t = 0; t < 2000; t++) begin
            cyc();
            en = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 199) == 0) gen2 = ~gen2;
            if ($urandom_range(0, 49) == 0) begin
                lock_v = 8'($urandom_range(0, 4));
                loss_v = 8'($urandom_range(0, 4));
            end
            rx = mk($urandom_range(0, 99) < 85, gen2);
        end
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
